// File: rtl/execute_stage_if.sv
// execute_stage_if: operand, control and result bundle of the execute stage.
// Signals: flag_src, data1, data2, imm, ALUsrc1/2, ALUoperation, mem_flags,
// input_flags, imm_val, data1_val, data2_val, prev_ALU, prev_mem (to stage);
// ALU_out, output_flags (from stage). master = driver side, slave = stage.
interface execute_stage_if;
    logic        flag_src;
    logic        data1;
    logic        data2;
    logic        imm;
    logic [1:0]  ALUsrc1;
    logic [1:0]  ALUsrc2;
    logic [2:0]  ALUoperation;
    logic [3:0]  mem_flags;
    logic [3:0]  input_flags;
    logic [15:0] imm_val;
    logic [15:0] data1_val;
    logic [15:0] data2_val;
    logic [15:0] prev_ALU;
    logic [15:0] prev_mem;
    logic [15:0] ALU_out;
    logic [3:0]  output_flags;

    modport master (
        output flag_src, data1, data2, imm,
        output ALUsrc1, ALUsrc2, ALUoperation,
        output mem_flags, input_flags,
        output imm_val, data1_val, data2_val,
        output prev_ALU, prev_mem,
        input  ALU_out, output_flags
    );

    modport slave (
        input  flag_src, data1, data2, imm,
        input  ALUsrc1, ALUsrc2, ALUoperation,
        input  mem_flags, input_flags,
        input  imm_val, data1_val, data2_val,
        input  prev_ALU, prev_mem,
        output ALU_out, output_flags
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: operand select + 8-op 16-bit ALU with Z/N/C/V flags.
// Ports: clk, rst (sync, active-high), bus (execute_stage_if.slave).
// Output flags: [0] Z, [1] N, [2] C, [3] V.
// Macro EXEC_OUT_REG_EN: register ALU_out/output_flags (1-cycle latency).
// Without it the stage is purely combinational and clk/rst are unused.
module execute_stage (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_INC  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic [15:0] w_srcA;
    logic [15:0] w_srcB;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [3:0]  w_f;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [16:0] w_inc;
    logic [15:0] w_res;
    logic [3:0]  w_flags;

    always_comb begin
        unique case (bus.ALUsrc1)
            2'b01:   w_srcA = bus.prev_ALU;
            2'b10:   w_srcA = bus.prev_mem;
            default: w_srcA = bus.data1_val;
        endcase
        unique case (bus.ALUsrc2)
            2'b01:   w_srcB = bus.prev_ALU;
            2'b10:   w_srcB = bus.prev_mem;
            default: w_srcB = bus.data2_val;
        endcase
    end

    assign w_a = bus.data1 ? w_srcA : 16'h0000;
    assign w_b = bus.imm   ? bus.imm_val :
                 bus.data2 ? w_srcB : 16'h0000;
    assign w_f = bus.flag_src ? bus.mem_flags : bus.input_flags;

    // Bit 16 of the difference is the borrow (A < B unsigned).
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_inc  = {1'b0, w_a} + 17'd1;

    always_comb begin
        w_res   = 16'h0000;
        w_flags = w_f;
        unique case (bus.ALUoperation)
            OP_ADD: begin
                w_res      = w_sum[15:0];
                w_flags[2] = w_sum[16];
                w_flags[3] = (w_a[15] == w_b[15]) &&
                             (w_res[15] != w_a[15]);
            end
            OP_SUB: begin
                w_res      = w_diff[15:0];
                w_flags[2] = w_diff[16];
                w_flags[3] = (w_a[15] != w_b[15]) &&
                             (w_res[15] != w_a[15]);
            end
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_NOT: w_res = ~w_a;
            OP_INC: begin
                w_res      = w_inc[15:0];
                w_flags[2] = w_inc[16];
                w_flags[3] = ~w_a[15] && w_res[15];
            end
            OP_MOV:  w_res = w_a;
            OP_PASS: w_res = w_b;
            default: w_res = 16'h0000;
        endcase
        // MOV and PASSB leave all flags as selected.
        if (bus.ALUoperation != OP_MOV &&
            bus.ALUoperation != OP_PASS) begin
            w_flags[0] = (w_res == 16'h0000);
            w_flags[1] = w_res[15];
        end
    end

`ifdef EXEC_OUT_REG_EN
    logic [15:0] r_alu_out;
    logic [3:0]  r_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= 16'h0000;
            r_flags   <= 4'b0000;
        end else begin
            r_alu_out <= w_res;
            r_flags   <= w_flags;
        end
    end

    assign bus.ALU_out      = r_alu_out;
    assign bus.output_flags = r_flags;
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst};

    assign bus.ALU_out      = w_res;
    assign bus.output_flags = w_flags;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with a queue-based scoreboard.
// Works for both the combinational and EXEC_OUT_REG_EN builds.
module tb_execute_stage;
    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic clk;
    logic rst;
    logic drv_vld;
    logic vld_q;
    logic out_vld;
    int   checks;
    int   errors;
    exp_t sb[$];

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) vld_q <= drv_vld;

`ifdef EXEC_OUT_REG_EN
    assign out_vld = vld_q;
`else
    assign out_vld = drv_vld;
`endif

    always @(negedge clk) begin
        if (out_vld === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s: output with empty scoreboard",
                         "sb_empty");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.ALU_out !== e.res ||
                    bus.output_flags !== e.flg) begin
                    errors++;
                    $display("FAIL %s: got %h/%b expected %h/%b",
                             e.name, bus.ALU_out,
                             bus.output_flags, e.res, e.flg);
                end
            end
        end
    end

    task automatic clr();
        bus.flag_src     = 1'b0;
        bus.data1        = 1'b1;
        bus.data2        = 1'b1;
        bus.imm          = 1'b0;
        bus.ALUsrc1      = 2'b00;
        bus.ALUsrc2      = 2'b00;
        bus.ALUoperation = 3'b000;
        bus.mem_flags    = 4'b0000;
        bus.input_flags  = 4'b0000;
        bus.imm_val      = 16'h0000;
        bus.data1_val    = 16'h0000;
        bus.data2_val    = 16'h0000;
        bus.prev_ALU     = 16'h0000;
        bus.prev_mem     = 16'h0000;
        rst              = 1'b0;
    endtask

    // Inputs are set by the caller just after a rising edge;
    // send() marks them valid and records the expected result.
    task automatic send(input string nm,
                        input logic [15:0] r,
                        input logic [3:0] f);
        exp_t e;
        e.name = nm;
        e.res  = r;
        e.flg  = f;
`ifdef EXEC_OUT_REG_EN
        if (rst) begin
            e.res = 16'h0000;
            e.flg = 4'b0000;
        end
`endif
        sb.push_back(e);
        drv_vld = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic op2(input logic [2:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
        step();
        bus.ALUoperation = op;
        bus.data1_val    = a;
        bus.data2_val    = b;
    endtask

    initial begin
        #100000;
        $display("FAIL %s: simulation time limit", "watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        drv_vld = 1'b0;
        vld_q   = 1'b0;
        clr();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        rst = 1'b1;
        bus.data1_val = 16'h1111;
        send("reset_state", 16'h1111, 4'b0000);

        op2(3'b000, 16'h0FFE, 16'h0000);
        send("add_0ffe", 16'h0FFE, 4'b0000);
        op2(3'b000, 16'hFFFF, 16'hFFFF);
        send("add_ffff_ffff", 16'hFFFE, 4'b0110);
        op2(3'b000, 16'h0000, 16'h0000);
        send("add_zero", 16'h0000, 4'b0001);
        op2(3'b010, 16'hFFFF, 16'h0001);
        bus.input_flags = 4'b1100;
        send("and_keep_cv", 16'h0001, 4'b1100);
        op2(3'b010, 16'h0FFE, 16'h0FFF);
        send("and_0ffe", 16'h0FFE, 4'b0000);

        step();
        bus.ALUsrc1  = 2'b01;
        bus.ALUsrc2  = 2'b10;
        bus.prev_ALU = 16'h1234;
        bus.prev_mem = 16'h0001;
        send("fwd_add", 16'h1235, 4'b0000);
        step();
        bus.ALUsrc1  = 2'b01;
        bus.ALUsrc2  = 2'b10;
        bus.prev_ALU = 16'h1234;
        bus.prev_mem = 16'h0001;
        bus.imm      = 1'b1;
        bus.imm_val  = 16'h0010;
        send("fwd_imm", 16'h1244, 4'b0000);

        op2(3'b110, 16'h8000, 16'h0000);
        bus.flag_src  = 1'b1;
        bus.mem_flags = 4'b1010;
        send("mov_memflags", 16'h8000, 4'b1010);
        op2(3'b110, 16'h8000, 16'h0000);
        bus.mem_flags = 4'b1010;
        send("mov_inflags", 16'h8000, 4'b0000);

        op2(3'b001, 16'h0001, 16'h0002);
        send("sub_borrow", 16'hFFFF, 4'b0110);
        op2(3'b001, 16'h8000, 16'h0001);
        send("sub_ovf", 16'h7FFF, 4'b1000);
        op2(3'b000, 16'h7FFF, 16'h0001);
        send("add_ovf", 16'h8000, 4'b1010);
        op2(3'b101, 16'hFFFF, 16'h1234);
        send("inc_wrap", 16'h0000, 4'b0101);
        op2(3'b100, 16'h00FF, 16'h0000);
        bus.input_flags = 4'b1100;
        send("not_keep_cv", 16'hFF00, 4'b1110);
        op2(3'b011, 16'h0F00, 16'h00F0);
        send("or", 16'h0FF0, 4'b0000);
        op2(3'b111, 16'h1234, 16'hBEEF);
        bus.input_flags = 4'b0101;
        send("passb", 16'hBEEF, 4'b0101);

        op2(3'b000, 16'h1234, 16'h0005);
        bus.data1 = 1'b0;
        send("data1_off", 16'h0005, 4'b0000);
        op2(3'b000, 16'h0003, 16'h7777);
        bus.data2 = 1'b0;
        send("data2_off", 16'h0003, 4'b0000);
        op2(3'b000, 16'h0002, 16'h0003);
        bus.ALUsrc1  = 2'b11;
        bus.ALUsrc2  = 2'b11;
        bus.prev_ALU = 16'h4000;
        bus.prev_mem = 16'h4000;
        send("src_11", 16'h0005, 4'b0000);

        op2(3'b000, 16'h0001, 16'h0002);
        send("add_1_2", 16'h0003, 4'b0000);
        op2(3'b000, 16'h0001, 16'h0002);
        rst = 1'b1;
        send("rst_midstream", 16'h0003, 4'b0000);
        op2(3'b000, 16'h0001, 16'h0002);
        send("add_after_rst", 16'h0003, 4'b0000);

        @(posedge clk);
        #1;
        drv_vld = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d left, expected 0",
                     "sb_drain", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline execute stage of the 16-bit core. It selects ALU operands from register data, forwarded results or the immediate, and performs one of eight ALU operations. It produces the 16-bit result and the 4-bit condition flags. It sits between the decode/register-read stage and the memory stage; the memory and write-back stages supply its forwarding paths.

## Interface
Parameters: none (datapath fixed at 16 bits, flags at 4 bits).

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flag_src  in  1  flag source for non-updating ops: 0 = input_flags, 1 = mem_flags.
- data1  in  1  operand A enable; 0 forces operand A to 0.
- data2  in  1  operand B enable; 0 forces operand B to 0 unless imm=1.
- imm  in  1  1 = operand B is imm_val, overriding ALUsrc2 and data2.
- ALUsrc1  in  2  operand A source: 00 data1_val, 01 prev_ALU, 10 prev_mem, 11 data1_val.
- ALUsrc2  in  2  operand B source, same encoding using data2_val.
- ALUoperation  in  3  operation code, see Operation.
- mem_flags  in  4  flags restored from memory (RTI/restore path).
- input_flags  in  4  current flag register value.
- imm_val, data1_val, data2_val  in  16  immediate and register operands.
- prev_ALU  in  16  forwarded result from EX/MEM.
- prev_mem  in  16  forwarded result from MEM/WB.
- ALU_out  out  16  ALU result.
- output_flags  out  4  next flags: [0] Z, [1] N, [2] C, [3] V.

## Operation
- Operand A = data1 ? mux(ALUsrc1) : 0.
- Operand B = imm ? imm_val : (data2 ? mux(ALUsrc2) : 0).
- Base flags F = flag_src ? mem_flags : input_flags.
- 000 ADD: A+B on a 17-bit sum. C = bit 16. V = signed overflow, set when A and B have equal signs and the result sign differs.
- 001 SUB: A−B. C = 1 on borrow (A < B, unsigned). V = signed overflow.
- 010 AND: A&B.
- 011 OR: A|B.
- 100 NOT: ~A.
- 101 INC: A+1, with C and V as for ADD with B=1.
- 110 MOV: result = A; no flag update.
- 111 PASSB: result = B; no flag update.
- Flag update by operation:
  - ADD, SUB, INC update Z, N, C and V.
  - AND, OR, NOT update Z and N, and pass C and V from F.
  - MOV and PASSB output F unchanged.
- Z = (result == 0). N = result[15]. All arithmetic is modulo 2^16.

## Timing
- Default build: fully combinational. ALU_out and output_flags are valid in the same cycle as the inputs (zero latency). clk and rst are unused and the block holds no state.
- The caller closes the flag loop externally through input_flags. The block does not register flags.
- No handshake; new inputs are accepted every cycle.
- With EXEC_OUT_REG_EN defined, see Configuration.

## Configuration
- EXEC_OUT_REG_EN defined:
  - ALU_out and output_flags are registered on rising clk, giving 1-cycle latency.
  - rst high at an edge loads ALU_out=0x0000 and output_flags=4'b0000.
  - Reset takes priority over new inputs; a reset mid-stream discards the in-flight result.
- EXEC_OUT_REG_EN undefined: combinational behaviour as above; rst has no effect.

## Test plan
- ADD with data1_val=0x0FFE, data2_val=0x0000, input_flags=0 → ALU_out=0x0FFE, flags Z0 N0 C0 V0.
- ADD 0xFFFF+0xFFFF → 0xFFFE, C=1, N=1, Z=0, V=0. Then ADD 0x0000+0x0000 → 0x0000, Z=1, C=0.
- AND 0xFFFF&0x0001 with input_flags C=1,V=1 → 0x0001, Z=0, N=0, C=1, V=1 retained. AND 0x0FFE&0x0FFF → 0x0FFE.
- Forwarding: ALUsrc1=01 with prev_ALU=0x1234, ALUsrc2=10 with prev_mem=0x0001, ADD → 0x1235. With imm=1 and imm_val=0x0010 → 0x1244.
- MOV with flag_src=1, mem_flags=4'b1010, input_flags=0 → ALU_out=A, output_flags=4'b1010. With flag_src=0 → output_flags=4'b0000.
- EXEC_OUT_REG_EN build: assert rst one edge → outputs 0. Then ADD 0x0001+0x0002 → 0x0003 appears one edge later.
